f_fetch_pc: RTL and testbench
=============================

Name: f_fetch_pc

Overview:
- Fetch-stage PC register and instruction-fetch sequencer that sits directly upstream of the decode-stage next-PC logic.
- Holds the fetch PC and issues one instruction request at a time to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched instruction to D, then advances to the next PC: PC+4, the D-stage redirect target (applied after the delay slot), the exception vector, or the EPC.

Parameters:
- RESET_PC, 32'h0000_3000, PC after reset.
- EXC_VECTOR, 32'h0000_4180, handler entry on exc_req.
- IMEM_LO, 32'h0000_3000, lowest legal fetch address.
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hazard unit: D cannot accept
- d_npc  in  32  D-stage redirect target
- d_is_npc  in  1  d_npc valid; the current D instruction is a branch/jump
- eret  in  1  return from exception
- epc  in  32  return address for eret
- exc_req  in  1  exception taken (from CP0)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- f_valid  out  1  f_instr/f_pc valid for D
- f_instr  out  32  instruction
- f_pc  out  32  PC of f_instr
- f_exc  out  5  0 = none, 4 = AdEL

Behaviour:
- Reset (async assert of rst_n): pc_q=RESET_PC, state=REQ, f_valid=0, f_instr=0, f_pc=0, f_exc=0, pend_v=0, discard=0. imem_req stays 0 while rst_n=0.
- States:
  - REQ: imem_req=1, imem_addr=pc_q. On imem_gnt go to WAIT.
  - WAIT: wait for imem_rvalid, which arrives at least 1 cycle after gnt.
    - On rvalid with discard=0: latch f_instr=imem_rdata, f_pc=pc_q, f_exc=0, f_valid=1, go to HOLD.
    - On rvalid with discard=1: drop the data, clear discard, go to REQ.
  - HOLD: f_valid=1 until consumed (f_valid && !stall).
    - On consume: pc_q = pend_v ? pend_pc : pc_q+4; clear pend_v; f_valid=0; go to REQ.
    - Consume-to-next-request latency is 1 cycle.
- Address check: evaluated in REQ before requesting. If pc_q[1:0]!=0 or pc_q<IMEM_LO or pc_q>IMEM_HI:
  - imem_req stays 0.
  - Load f_instr=0 (nop), f_pc=pc_q, f_exc=4, f_valid=1 directly; go to HOLD.
- D redirect: d_is_npc && !stall in any cycle latches pend_pc=d_npc, pend_v=1.
  - The in-flight or held instruction is the delay slot and is never discarded.
  - The target is applied on the next consume.
  - A second d_is_npc before that consume overwrites pend_pc.
- Global redirect: exc_req (highest priority) or eret loads pc_q=EXC_VECTOR or epc, clears f_valid and pend_v, and ignores stall.
  - REQ: stay in REQ; the new address is driven next cycle.
  - REQ with gnt in the same cycle, or WAIT: set discard=1 unless imem_rvalid is also high this cycle; go to WAIT. The next request is issued after the discarded response.
  - HOLD: go to REQ.
- Simultaneous events:
  - exc_req beats eret, which beats d_is_npc; the lower-priority redirect is dropped.
  - rvalid and a global redirect in the same cycle: the data is dropped and the state goes to REQ.
- pc_q+4 wraps modulo 2^32; no exception is raised until the wrapped address fails the check.
- Reset mid-fetch: all state is cleared. Any late imem_rvalid arriving in REQ is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_fetch (32-bit, increments on each non-discarded rvalid) and perf_stall (32-bit, increments each cycle in HOLD with stall=1).
  - Both counters reset to 0 and wrap.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, gnt same cycle, rvalid 1 cycle later -> imem_addr=0x3000; f_valid=1, f_pc=0x3000; after consume, imem_addr=0x3004.
- d_is_npc with d_npc=0x3100 while fetching 0x3004 -> 0x3004 is delivered (delay slot); the next imem_addr is 0x3100.
- exc_req in WAIT at pc 0x3008 -> rvalid data dropped, f_valid stays 0; next imem_addr=0x4180.
- eret with epc=0x3010 in HOLD and stall=1 -> f_valid=0 next cycle; imem_addr=0x3010.
- d_npc=0x3002 taken -> no imem_req; f_exc=4, f_instr=0, f_pc=0x3002. Repeat with d_npc=0x7000 -> same result with f_pc=0x7000.
- stall held 5 cycles in HOLD -> f_instr, f_pc stable and no new imem_req. With FETCH_PERF_CNT_EN defined, perf_stall=5.

Source files
------------

// File: rtl/f_fetch_pc_if.sv
// Instruction-memory request bus between the fetch sequencer and instruction memory.
// One request is outstanding at a time: req/addr until gnt, then a single rvalid/rdata beat.
interface f_fetch_pc_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/f_fetch_pc.sv
// Fetch-stage PC register and single-outstanding instruction fetch sequencer feeding D.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch / perf_stall counters.
//
// state  | meaning
// S_REQ  | drive imem req at pc_q, or raise AdEL directly if pc_q is illegal
// S_WAIT | request granted, waiting for rvalid (dropped if discard is set)
// S_HOLD | f_instr/f_pc presented to D until consumed or globally redirected
module f_fetch_pc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI    = 32'h0000_6FFC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic [31:0]  d_npc,
    input  logic         d_is_npc,
    input  logic         eret,
    input  logic [31:0]  epc,
    input  logic         exc_req,
    f_fetch_pc_if.master imem,
    output logic         f_valid,
    output logic [31:0]  f_instr,
    output logic [31:0]  f_pc,
    output logic [4:0]   f_exc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetch,
    output logic [31:0]  perf_stall
`endif
);

    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pend_pc;
    logic        pend_v;
    logic        discard;

    logic        addr_ok;
    logic        gnt_acc;
    logic        glob;
    logic [31:0] glob_pc;
    logic        consume;
    logic        d_take;

    assign addr_ok   = (pc_q[1:0] == 2'b00) && (pc_q >= IMEM_LO) && (pc_q <= IMEM_HI);
    // Gated by rst_n so no request escapes while reset is held.
    assign imem.req  = rst_n && (state == S_REQ) && addr_ok;
    assign imem.addr = pc_q;
    assign gnt_acc   = imem.req && imem.gnt;
    assign glob      = exc_req || eret;
    assign glob_pc   = exc_req ? EXC_VECTOR : epc;
    assign consume   = f_valid && !stall;
    assign d_take    = d_is_npc && !stall && !glob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_REQ;
            pc_q    <= RESET_PC;
            pend_pc <= 32'd0;
            pend_v  <= 1'b0;
            discard <= 1'b0;
            f_valid <= 1'b0;
            f_instr <= 32'd0;
            f_pc    <= 32'd0;
            f_exc   <= 5'd0;
        end else if (glob) begin
            pc_q    <= glob_pc;
            pend_v  <= 1'b0;
            f_valid <= 1'b0;
            case (state)
                S_REQ: begin
                    // A request granted this cycle still owes a response; swallow it.
                    if (gnt_acc) begin
                        discard <= 1'b1;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        discard <= 1'b0;
                        state   <= S_REQ;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (!addr_ok) begin
                        f_instr <= 32'd0;
                        f_pc    <= pc_q;
                        f_exc   <= EXC_ADEL;
                        f_valid <= 1'b1;
                        state   <= S_HOLD;
                    end else if (imem.gnt) begin
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= S_REQ;
                        end else begin
                            f_instr <= imem.rdata;
                            f_pc    <= pc_q;
                            f_exc   <= 5'd0;
                            f_valid <= 1'b1;
                            state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        pc_q    <= pend_v ? pend_pc : pc_q + 32'd4;
                        pend_v  <= 1'b0;
                        f_valid <= 1'b0;
                        state   <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
            // A redirect seen in the consume cycle belongs to the next consume, so it wins over the clear.
            if (d_take) begin
                pend_pc <= d_npc;
                pend_v  <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch <= 32'd0;
            perf_stall <= 32'd0;
        end else begin
            if ((state == S_WAIT) && imem.rvalid && !discard && !glob) begin
                perf_fetch <= perf_fetch + 32'd1;
            end
            if ((state == S_HOLD) && stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_f_fetch_pc.sv
// Scoreboard bench for f_fetch_pc: random memory latency/grants and random D/CP0 redirects
// checked against an instruction-stream reference model.
module tb_f_fetch_pc;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IMEM_LO    = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI    = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] d_npc = 32'd0;
    logic        d_is_npc = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = 32'd0;
    logic        exc_req = 1'b0;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic [4:0]  f_exc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    f_fetch_pc_if imem();

    f_fetch_pc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .d_npc    (d_npc),
        .d_is_npc (d_is_npc),
        .eret     (eret),
        .epc      (epc),
        .exc_req  (exc_req),
        .imem     (imem),
        .f_valid  (f_valid),
        .f_instr  (f_instr),
        .f_pc     (f_pc),
        .f_exc    (f_exc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   presented = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= IMEM_LO) && (a <= IMEM_HI);
    endfunction

    function automatic exp_t expect_at(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        if (legal(pc)) begin
            e.instr = mem_word(pc);
            e.exc   = 5'd0;
        end else begin
            e.instr = 32'd0;
            e.exc   = 5'd4;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: next PC the instruction stream must present, updated for each coming edge.
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic        m_pend_v;
    logic        gnt_seen = 1'b0;
    logic [31:0] seen_addr = 32'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            m_pc     = RESET_PC;
            m_pend_v = 1'b0;
            m_pend   = 32'd0;
            sbq.push_back(expect_at(RESET_PC));
            gnt_seen = 1'b0;
        end else begin
            gnt_seen  = imem.req && imem.gnt;
            seen_addr = imem.addr;
            if (imem.req) begin
                check("req_addr", imem.addr, m_pc);
                check("req_legal", {31'd0, legal(imem.addr)}, 32'd1);
            end
            if (exc_req || eret) begin
                m_pc     = exc_req ? EXC_VECTOR : epc;
                m_pend_v = 1'b0;
                sbq.delete();
                sbq.push_back(expect_at(m_pc));
            end else begin
                if (f_valid && !stall) begin
                    m_pc     = m_pend_v ? m_pend : m_pc + 32'd4;
                    m_pend_v = 1'b0;
                    sbq.push_back(expect_at(m_pc));
                end
                if (d_is_npc && !stall) begin
                    m_pend   = d_npc;
                    m_pend_v = 1'b1;
                end
            end
        end
    end

    // Instruction memory: random grant, response 1..3 cycles after the grant edge.
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;

    initial begin
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = 32'd0;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mem_busy    = 1'b0;
            imem.rvalid = 1'b0;
            imem.gnt    = 1'b0;
        end else begin
            imem.rvalid = 1'b0;
            if (gnt_seen) begin
                mem_busy = 1'b1;
                mem_cnt  = int'($urandom_range(1, 3));
                mem_addr = seen_addr;
            end
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem.rvalid = 1'b1;
                    imem.rdata  = mem_word(mem_addr);
                    mem_busy    = 1'b0;
                end
            end
            imem.gnt = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops an expectation on every new presentation; checks stability while held.
    logic        fv_prev = 1'b0;
    logic [31:0] held_pc = 32'd0;
    logic [31:0] held_instr = 32'd0;

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            fv_prev = 1'b0;
        end else begin
            if (f_valid && !fv_prev) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch: got pc %08h expected no presentation", f_pc);
                end else begin
                    e = sbq.pop_front();
                    check("f_pc", f_pc, e.pc);
                    check("f_instr", f_instr, e.instr);
                    check("f_exc", {27'd0, f_exc}, {27'd0, e.exc});
                    presented++;
                end
                held_pc    = f_pc;
                held_instr = f_instr;
            end else if (f_valid) begin
                check("hold_pc", f_pc, held_pc);
                check("hold_instr", f_instr, held_instr);
                check("hold_no_req", {31'd0, imem.req}, 32'd0);
            end
            fv_prev = f_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (!f_valid && n < budget) begin
            step();
            n++;
        end
        check({"wait_valid_", tag}, {31'd0, f_valid}, 32'd1);
    endtask

    task automatic wait_gnt(input int budget);
        int n = 0;
        while (!(imem.req && imem.gnt) && n < budget) begin
            step();
            n++;
        end
        check("wait_gnt", {31'd0, imem.req && imem.gnt}, 32'd1);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        if ($urandom_range(0, 9) == 0) return $urandom;
        r = $urandom_range(32'h0C00, 32'h1BFF);
        return {r[29:0], 2'b00};
    endfunction

    initial begin
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] ps0;
`endif
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_req", {31'd0, imem.req}, 32'd0);
        check("rst_f_valid", {31'd0, f_valid}, 32'd0);
        check("rst_f_pc", f_pc, 32'd0);
        check("rst_f_exc", {27'd0, f_exc}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_addr", imem.addr, RESET_PC);
        check("rst_req_after", {31'd0, imem.req}, 32'd1);

        // First fetch, then a redirect while fetching the delay slot.
        wait_valid(30, "first");
        step();
        d_is_npc = 1'b1;
        d_npc    = 32'h0000_3100;
        step();
        d_is_npc = 1'b0;
        wait_valid(30, "delay_slot");
        step();
        wait_valid(30, "target");

        // Exception while waiting for a response.
        wait_gnt(30);
        step();
        exc_req = 1'b1;
        step();
        exc_req = 1'b0;
        check("exc_wait_f_valid", {31'd0, f_valid}, 32'd0);
        wait_valid(30, "exc_vector");

        // eret while held and stalled.
        stall = 1'b1;
        eret  = 1'b1;
        epc   = 32'h0000_3010;
        step();
        eret  = 1'b0;
        check("eret_f_valid", {31'd0, f_valid}, 32'd0);
        check("eret_addr", imem.addr, 32'h0000_3010);
        stall = 1'b0;
        wait_valid(30, "eret_target");

        // Misaligned and out-of-range redirects raise AdEL without a request.
        d_is_npc = 1'b1;
        d_npc    = 32'h0000_3002;
        step();
        d_is_npc = 1'b0;
        wait_valid(30, "ds1");
        step();
        wait_valid(30, "adel1");
        check("adel1_pc", f_pc, 32'h0000_3002);
        check("adel1_exc", {27'd0, f_exc}, 32'd4);
        check("adel1_instr", f_instr, 32'd0);
        check("adel1_noreq", {31'd0, imem.req}, 32'd0);
        d_is_npc = 1'b1;
        d_npc    = 32'h0000_7000;
        step();
        d_is_npc = 1'b0;
        wait_valid(30, "ds2");
        step();
        wait_valid(30, "adel2");
        check("adel2_pc", f_pc, 32'h0000_7000);
        check("adel2_exc", {27'd0, f_exc}, 32'd4);

        // Five stalled cycles in HOLD.
        stall = 1'b1;
`ifdef FETCH_PERF_CNT_EN
        ps0 = perf_stall;
`endif
        repeat (5) step();
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall", perf_stall - ps0, 32'd5);
`endif
        check("stall_f_valid", {31'd0, f_valid}, 32'd1);
        stall   = 1'b0;
        exc_req = 1'b1;
        step();
        exc_req = 1'b0;

        // Reset in the middle of traffic.
        repeat (3) step();
        rst_n = 1'b0;
        repeat (2) step();
        check("midrst_f_valid", {31'd0, f_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_addr", imem.addr, RESET_PC);

        for (int i = 0; i < 3000; i++) begin
            stall    = ($urandom_range(0, 9) < 3);
            d_is_npc = ($urandom_range(0, 9) == 0);
            d_npc    = rand_target();
            exc_req  = ($urandom_range(0, 49) == 0);
            eret     = ($urandom_range(0, 29) == 0);
            epc      = rand_target();
            step();
        end
        stall    = 1'b0;
        d_is_npc = 1'b0;
        exc_req  = 1'b0;
        eret     = 1'b0;
        repeat (10) step();

        check("presentations", {31'd0, presented > 200}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
